pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush (bubble-insert) inputs of the PC, IF/ID, ID/EXE and EXE/MEM registers, plus a bubble into MEM/WB.
- Resolves three hazard classes: load-use data hazards, taken branches resolved in EXE, and multi-cycle data-memory waits.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 49 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 59 +++++
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared encodings for the pipeline hazard sequencer: register
//               address width, counter width, FSM state encodings and the
//               canned control vectors driven onto the pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // Register-file address width; hazard comparisons track this
    localparam int REG_FILE_ADDR_LEN = 5;

    // Default width of the stall/flush performance counters
    localparam int HZ_CNT_W = 16;

    // Sequencer state encodings
    localparam logic [0:0] HZ_STATE_RUN      = 1'b0;
    localparam logic [0:0] HZ_STATE_MEM_WAIT = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN      = HZ_STATE_RUN,
        ST_MEM_WAIT = HZ_STATE_MEM_WAIT
    } hz_state_t;

    // One bundle of every pipeline-register control the sequencer owns
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_exe_en;
        logic id_exe_flush;
        logic exe_mem_en;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    // Normal flow: everything advances, nothing squashed
    localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Reset: hold every register and push NOPs/bubbles everywhere
    localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // Data-memory wait: whole pipe frozen, WB sees a bubble
    localparam hz_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Taken branch: squash the two wrong-path instructions in IF/ID and ID/EXE
    localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Data hazard: hold PC and IF/ID, inject a bubble into EXE, let older work drain
    localparam hz_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational RAW hazard detector for the instruction in ID.
//               With forwarding only a load in EXE can force a stall; without
//               forwarding any writer in EXE or MEM does.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = REG_FILE_ADDR_LEN,
    parameter int FWD_EN = 1
) (
    input  logic [ADDR_W-1:0] id_src1,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [ADDR_W-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              hazard
);

    logic w_exe_hit;
    logic w_mem_hit;
    logic w_load_use;
    logic w_raw_any;

    // A destination hits when it is non-zero and feeds one of the live sources;
    // register 0 is hardwired so it never creates a dependency
    function automatic logic reg_hit(
        input logic [ADDR_W-1:0] r,
        input logic [ADDR_W-1:0] s1,
        input logic [ADDR_W-1:0] s2,
        input logic              two
    );
        return (r != '0) && ((r == s1) || (two && (r == s2)));
    endfunction

    // Both hazard flavours are always formed; the parameter picks which one counts
    always_comb begin
        w_exe_hit  = reg_hit(exe_dest, id_src1, id_src2, id_two_src);
        w_mem_hit  = reg_hit(mem_dest, id_src1, id_src2, id_two_src);
        w_load_use = exe_mem_r_en && w_exe_hit;
        w_raw_any  = (exe_wb_en && w_exe_hit) || (mem_wb_en && w_mem_hit);
    end

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign hazard = w_load_use;
        end else begin : g_no_fwd
            assign hazard = w_raw_any;
        end
    endgenerate

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Freezes on data-memory waits, squashes on taken branches,
//               stalls on data hazards, counts stalls/flushes and flags a
//               sticky memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W      = REG_FILE_ADDR_LEN,
    parameter int CNT_W       = HZ_CNT_W,
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] id_src1,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [ADDR_W-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_exe_en,
    output logic              id_exe_flush,
    output logic              exe_mem_en,
    output logic              mem_wb_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_err
);

    // Wait counter only needs to reach the timeout value, where it saturates
    localparam int               C_WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(MEM_TIMEOUT);
    localparam logic [C_WAIT_W-1:0] C_WAIT_ONE = C_WAIT_W'(1);
    localparam logic [CNT_W-1:0]    C_CNT_MAX  = '1;

    hz_state_t             r_state;
    hz_state_t             w_state_nxt;
    logic [C_WAIT_W-1:0]   r_wait_cnt;
    logic [C_WAIT_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;
    logic                  r_mem_err;
    logic                  w_hazard;
    logic                  w_freeze;
    logic                  w_branch;
    hz_ctrl_t              w_ctrl;

    hazard_detect #(
        .ADDR_W (ADDR_W),
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (w_hazard)
    );

    // Next-state logic and prioritised control muxing (freeze > branch > hazard)
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_freeze    = 1'b0;
        w_branch    = 1'b0;
        w_ctrl      = CTRL_RUN;

        unique case (r_state)
            ST_RUN: begin
                // A request that completes in the same cycle costs nothing
                if (mem_req && !mem_ready) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = C_WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    w_freeze = 1'b1;
                    if (r_wait_cnt != C_WAIT_MAX) begin
                        w_wait_nxt = r_wait_cnt + C_WAIT_ONE;
                    end
                end else begin
                    // Release cycle: the normal RUN priorities apply to the held instructions
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase

        // EXE is held during a freeze, so a branch there is only acted on at release;
        // a branch beats a data hazard because the ID instruction is squashed anyway
        if (w_freeze) begin
            w_ctrl = CTRL_FREEZE;
        end else if (br_taken) begin
            w_ctrl   = CTRL_BRANCH;
            w_branch = 1'b1;
        end else if (w_hazard) begin
            w_ctrl = CTRL_STALL;
        end

        if (rst) begin
            w_ctrl   = CTRL_RESET;
            w_branch = 1'b0;
        end
    end

    // FSM state and memory-wait counter; reset abandons any wait in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Saturating stall/flush performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctrl.pc_en && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_branch && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Sticky timeout flag, raised on the frozen cycle that brings the wait count to the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else if (w_freeze && (w_wait_nxt == C_WAIT_MAX)) begin
            r_mem_err <= 1'b1;
        end
    end

    assign pc_en         = w_ctrl.pc_en;
    assign if_id_en      = w_ctrl.if_id_en;
    assign if_id_flush   = w_ctrl.if_id_flush;
    assign id_exe_en     = w_ctrl.id_exe_en;
    assign id_exe_flush  = w_ctrl.id_exe_flush;
    assign exe_mem_en    = w_ctrl.exe_mem_en;
    assign mem_wb_bubble = w_ctrl.mem_wb_bubble;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;
    assign mem_err       = r_mem_err;

endmodule : pipe_hazard_ctrl
`default_nettype wire
